// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between decode/EX stage logic and the hazard controller.
//   master : pipeline side; drives ID/EX operand info and branch resolution,
//            consumes the enables, flush, bubble select and debug counters.
//   slave  : hazard_ctrl side.
interface hazard_ctrl_if #(
  parameter int REG_AW = 3
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              br_taken;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              ctrl_bubble_sel;
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd, br_taken,
    input  pc_write, ifid_write, ifid_flush, ctrl_bubble_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd, br_taken,
    output pc_write, ifid_write, ifid_flush, ctrl_bubble_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: IF/ID/EX hazard controller.
//   Detects load-use hazards (one-cycle stall + bubble) and taken branches
//   (BR_FLUSH_CYCLES cycles of IF/ID flush + bubble). Keeps saturating
//   stall/flush event counters for performance debug.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; also forces the pipeline controls
//           to their safe values combinationally while low
//   hz    : hazard_ctrl_if.slave (ID/EX operand info, br_taken in;
//           pc_write, ifid_write, ifid_flush, ctrl_bubble_sel, counters out)
module hazard_ctrl #(
  parameter int REG_AW          = 3,
  parameter int BR_FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [15:0] stall_q, flush_q;
  logic        lu_hazard;
  logic        stall_ev;
  logic        pc_write, ifid_write, ifid_flush, bubble_sel;

  // Register 0 is hardwired zero, so a load targeting it can never be a hazard.
  assign lu_hazard = hz.ex_mem_read && (hz.ex_rd != '0) &&
                     ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                      (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    bubble_sel = 1'b0;
    stall_ev   = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.br_taken) begin
          ifid_flush = 1'b1;
          bubble_sel = 1'b1;
          if (BR_FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = 4'(BR_FLUSH_CYCLES - 1);
          end
        end else if (lu_hazard) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          bubble_sel = 1'b1;
          stall_ev   = 1'b1;
        end
      end
      FLUSH: begin
        // Anything in ID/EX now is wrong-path, so br_taken/lu_hazard are ignored.
        ifid_flush = 1'b1;
        bubble_sel = 1'b1;
        fcnt_d     = fcnt_q - 4'd1;
        if (fcnt_q == 4'd1) begin
          state_d = RUN;
          fcnt_d  = 4'd0;
        end
      end
      default: state_d = RUN;
    endcase
    // Reset overrides everything: hold PC/IF-ID and keep NOPs flowing.
    if (!rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      bubble_sel = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      fcnt_q  <= 4'd0;
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (stall_ev && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
      if (ifid_flush && (flush_q != 16'hFFFF))
        flush_q <= flush_q + 16'd1;
    end
  end

  assign hz.pc_write        = pc_write;
  assign hz.ifid_write      = ifid_write;
  assign hz.ifid_flush      = ifid_flush;
  assign hz.ctrl_bubble_sel = bubble_sel;
  assign hz.stall_cnt       = stall_q;
  assign hz.flush_cnt       = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default (2-cycle flush) instance and a
// 4-cycle-flush instance used for the mid-flush reset case.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n, rst4_n;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(3)) hz ();
  hazard_ctrl_if #(.REG_AW(3)) hz4 ();

  hazard_ctrl #(.REG_AW(3), .BR_FLUSH_CYCLES(2)) dut  (.clk(clk), .rst_n(rst_n),  .hz(hz.slave));
  hazard_ctrl #(.REG_AW(3), .BR_FLUSH_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst4_n), .hz(hz4.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // pc_write, ifid_write, ifid_flush, ctrl_bubble_sel packed as 4 bits
  function automatic logic [3:0] ctl(input logic p, input logic w, input logic f, input logic b);
    return {p, w, f, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
    hz.ex_mem_read = 1'b0; hz.ex_rd = '0; hz.br_taken = 1'b0;
  endtask

  initial begin
    idle();
    hz4.id_rs = '0; hz4.id_rt = '0; hz4.id_uses_rs = 1'b0; hz4.id_uses_rt = 1'b0;
    hz4.ex_mem_read = 1'b0; hz4.ex_rd = '0; hz4.br_taken = 1'b0;
    rst_n = 1'b0; rst4_n = 1'b0;
    #1;
    chk("reset_ctl", ctl(hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.ctrl_bubble_sel), 4'b0011);
    tick(); tick();
    chk("reset_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(hz.flush_cnt), 32'd0);
    rst_n = 1'b1; rst4_n = 1'b1;
    #1;
    chk("run_ctl", ctl(hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.ctrl_bubble_sel), 4'b1100);

    // load-use on rs
    hz.ex_mem_read = 1'b1; hz.ex_rd = 3'd3; hz.id_rs = 3'd3; hz.id_uses_rs = 1'b1;
    #1 chk("lu_rs_ctl", ctl(hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.ctrl_bubble_sel), 4'b0001);
    tick();
    hz.ex_mem_read = 1'b0;
    #1 chk("lu_after_ctl", ctl(hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.ctrl_bubble_sel), 4'b1100);
    chk("lu_stall_cnt", 32'(hz.stall_cnt), 32'd1);

    // load-use on rt, then back-to-back new load
    idle();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 3'd6; hz.id_rt = 3'd6; hz.id_uses_rt = 1'b1;
    #1 chk("lu_rt_ctl", ctl(hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.ctrl_bubble_sel), 4'b0001);
    tick();
    chk("lu_rt_cnt", 32'(hz.stall_cnt), 32'd2);
    hz.id_rs = 3'd2; hz.id_uses_rs = 1'b1; hz.ex_rd = 3'd2; hz.id_uses_rt = 1'b0;
    #1 chk("lu_b2b_ctl", ctl(hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.ctrl_bubble_sel), 4'b0001);
    tick();
    chk("lu_b2b_cnt", 32'(hz.stall_cnt), 32'd3);

    // register 0 never hazards
    idle();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 3'd0; hz.id_rs = 3'd0; hz.id_uses_rs = 1'b1;
    #1 chk("r0_ctl", ctl(hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.ctrl_bubble_sel), 4'b1100);
    tick();
    // unused operand never hazards
    idle();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 3'd5; hz.id_rt = 3'd5; hz.id_uses_rt = 1'b0;
    hz.id_rs = 3'd1; hz.id_uses_rs = 1'b1;
    #1 chk("unused_ctl", ctl(hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.ctrl_bubble_sel), 4'b1100);
    tick();
    chk("no_stall_cnt", 32'(hz.stall_cnt), 32'd3);

    // branch, N=2; second-cycle br_taken ignored
    idle();
    hz.br_taken = 1'b1;
    #1 chk("br_c1_ctl", ctl(hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.ctrl_bubble_sel), 4'b1111);
    tick();
    #1 chk("br_c2_ctl", ctl(hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.ctrl_bubble_sel), 4'b1111);
    tick();
    hz.br_taken = 1'b0;
    #1 chk("br_done_ctl", ctl(hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.ctrl_bubble_sel), 4'b1100);
    chk("br_flush_cnt", 32'(hz.flush_cnt), 32'd2);

    // branch wins over load-use; hazard during FLUSH ignored
    hz.br_taken = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_rd = 3'd3; hz.id_rs = 3'd3; hz.id_uses_rs = 1'b1;
    #1 chk("br_lu_ctl", ctl(hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.ctrl_bubble_sel), 4'b1111);
    tick();
    hz.br_taken = 1'b0;
    #1 chk("flush_lu_ctl", ctl(hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.ctrl_bubble_sel), 4'b1111);
    chk("br_lu_stall_cnt", 32'(hz.stall_cnt), 32'd3);
    tick();
    chk("br_lu_flush_cnt", 32'(hz.flush_cnt), 32'd4);
    chk("br_lu_stall_cnt2", 32'(hz.stall_cnt), 32'd3);
    idle();

    // N=4: full flush length
    hz4.br_taken = 1'b1;
    #1 chk("n4_c1", 32'(hz4.ifid_flush), 32'd1);
    tick();
    hz4.br_taken = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      #1 chk($sformatf("n4_c%0d", i), 32'(hz4.ifid_flush), 32'd1);
      tick();
    end
    #1 chk("n4_done_ctl", ctl(hz4.pc_write, hz4.ifid_write, hz4.ifid_flush, hz4.ctrl_bubble_sel), 4'b1100);
    chk("n4_flush_cnt", 32'(hz4.flush_cnt), 32'd4);

    // N=4: reset in first FLUSH cycle aborts the flush
    hz4.br_taken = 1'b1;
    tick();
    hz4.br_taken = 1'b0;
    rst4_n = 1'b0;
    #1 chk("n4_rst_ctl", ctl(hz4.pc_write, hz4.ifid_write, hz4.ifid_flush, hz4.ctrl_bubble_sel), 4'b0011);
    tick();
    chk("n4_rst_flush_cnt", 32'(hz4.flush_cnt), 32'd0);
    chk("n4_rst_stall_cnt", 32'(hz4.stall_cnt), 32'd0);
    rst4_n = 1'b1;
    #1 chk("n4_post_rst_ctl", ctl(hz4.pc_write, hz4.ifid_write, hz4.ifid_flush, hz4.ctrl_bubble_sel), 4'b1100);

    // stall counter saturation: 3 -> 0xFFFE, then 3 more
    hz.ex_mem_read = 1'b1; hz.ex_rd = 3'd4; hz.id_rs = 3'd4; hz.id_uses_rs = 1'b1;
    repeat (65531) @(posedge clk);
    #1 chk("sat_fffe", 32'(hz.stall_cnt), 32'hFFFE);
    tick();
    chk("sat_ffff", 32'(hz.stall_cnt), 32'hFFFF);
    tick(); tick();
    chk("sat_hold", 32'(hz.stall_cnt), 32'hFFFF);
    chk("sat_flush_cnt", 32'(hz.flush_cnt), 32'd4);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the processor's IF/ID/EX front end. It detects load-use hazards and taken-branch redirects. It then drives the select lines of the 1-bit 2:1 control-zeroing muxes (bubble insertion), the PC and IF/ID write enables, and the IF/ID flush. It also keeps saturating stall and flush event counters for performance debug. It sits between decode and the ID/EX control muxes, which consume `ctrl_bubble_sel`.

## Interface
- `REG_AW`, default 3: register-address width.
- `BR_FLUSH_CYCLES`, default 2: total cycles of flush per taken branch, legal range 1..15.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `id_rs` in REG_AW: source register 1 of the instruction in ID.
- `id_rt` in REG_AW: source register 2 of the instruction in ID.
- `id_uses_rs` in 1: ID instruction reads rs.
- `id_uses_rt` in 1: ID instruction reads rt.
- `ex_mem_read` in 1: instruction in EX is a load.
- `ex_rd` in REG_AW: destination register of the EX instruction.
- `br_taken` in 1: branch in EX resolved taken this cycle.
- `pc_write` out 1: PC register load enable.
- `ifid_write` out 1: IF/ID register load enable.
- `ifid_flush` out 1: IF/ID register clear to NOP.
- `ctrl_bubble_sel` out 1: select for the ID/EX control-zeroing muxes; 1 = insert bubble.
- `stall_cnt` out 16: count of load-use stall cycles, saturating.
- `flush_cnt` out 16: count of flush cycles, saturating.

## Operation
- Registered FSM with two states, RUN and FLUSH, plus a 4-bit down-counter `fcnt`.
- `lu_hazard` = `ex_mem_read` & (`ex_rd` != 0) & ((`id_uses_rs` & `id_rs`==`ex_rd`) | (`id_uses_rt` & `id_rt`==`ex_rd`)).
  - Register 0 never causes a hazard.
- Outputs in RUN, in priority order:
  - `br_taken`=1: `ifid_flush`=1, `ctrl_bubble_sel`=1, `pc_write`=1, `ifid_write`=1. If `BR_FLUSH_CYCLES`>1, next state is FLUSH with `fcnt`=`BR_FLUSH_CYCLES`-1; otherwise remain in RUN. Branch wins over a simultaneous `lu_hazard`.
  - `lu_hazard`=1 (no branch): `pc_write`=0, `ifid_write`=0, `ifid_flush`=0, `ctrl_bubble_sel`=1. Remain in RUN. The hazard clears once the bubble reaches EX.
  - Otherwise: `pc_write`=1, `ifid_write`=1, `ifid_flush`=0, `ctrl_bubble_sel`=0.
- Outputs in FLUSH: `ifid_flush`=1, `ctrl_bubble_sel`=1, `pc_write`=1, `ifid_write`=1.
  - `fcnt` decrements each cycle; when `fcnt`==1, next state is RUN.
  - `br_taken` and `lu_hazard` are ignored in FLUSH (they come from wrong-path instructions).
- Counters:
  - `stall_cnt` += 1 on each clock where RUN & ~`br_taken` & `lu_hazard`.
  - `flush_cnt` += 1 on each clock where `ifid_flush`=1.
  - Both saturate at 0xFFFF and never wrap.
- Reset (`rst_n`=0 at a rising edge): state RUN, `fcnt`=0, both counters 0.
  - While `rst_n`=0, outputs are forced combinationally: `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `ctrl_bubble_sel`=1. This overrides all other terms.
  - Reset asserted mid-FLUSH aborts the flush; the first cycle after reset release is RUN.

## Timing
- State, `fcnt`, `stall_cnt` and `flush_cnt` update on the rising edge of `clk`.
- `pc_write`, `ifid_write`, `ifid_flush` and `ctrl_bubble_sel` are combinational from state, `rst_n` and current inputs. They take effect at the same edge at which the pipeline registers sample them, so latency is zero cycles.
- Branch flush occupies exactly `BR_FLUSH_CYCLES` consecutive cycles, starting in the cycle `br_taken` is sampled high.
- Load-use stall lasts one cycle per hazard occurrence. A back-to-back hazard against a new EX load produces a new stall.
- Counter outputs reflect events up to and including the previous edge.
- No combinational path from any output back to any input.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=3, `id_rs`=3, `id_uses_rs`=1, one cycle -> that cycle `pc_write`=0, `ifid_write`=0, `ctrl_bubble_sel`=1; next cycle with `ex_mem_read`=0 all outputs return to run values; `stall_cnt`=1.
- Register-0 and unused-operand cases:
  - `ex_rd`=0 with `id_rs`=0 -> no stall.
  - `id_rt`=`ex_rd`=5 with `id_uses_rt`=0 -> no stall.
- Branch with default N=2: `br_taken` pulse -> `ifid_flush`=1 for exactly 2 cycles, `pc_write`=1 throughout; `br_taken` asserted in the second cycle is ignored; `flush_cnt`=2.
- Simultaneous `br_taken` and `lu_hazard` -> flush behaviour, `pc_write`=1, `stall_cnt` unchanged.
- Reset: `rst_n`=0 during cycle 1 of FLUSH with `BR_FLUSH_CYCLES`=4 -> outputs forced to reset values, counters 0, RUN outputs on the first cycle after release.
- Saturation: force `stall_cnt` to 0xFFFE via 65534 hazard cycles (or a backdoor load), then 3 more hazard cycles -> `stall_cnt` holds 0xFFFF.
